fifo_rd_status: RTL and testbench

Read-domain pointer and status engine for the asynchronous FIFO. It replaces the standalone empty detector. The block generates the binary read address and the Gray-coded read pointer. It also produces a registered empty flag, a programmable almost-empty flag, a registered fill count and a sticky underflow flag. All logic runs in the read clock domain. Its inputs are the synchronized Gray write pointer and the consumer's read request.

---
 rtl/fifo_rd_status_if.sv | 26 ++
 rtl/fifo_rd_status.sv | 77 +++++++
 tb/tb_fifo_rd_status.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_status_if.sv
// Consumer-side bundle of the FIFO read-domain status engine, plus the
// Gray pointers exchanged with the write-domain synchronizers.
interface fifo_rd_status_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   wr_ptr_gray_sync;
    logic [ADDR_WIDTH:0]   ae_level;
    logic                  underflow_clr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   rd_ptr_gray;
    logic                  rd_empty;
    logic                  rd_almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  rd_underflow;

    modport master (
        output rd_en, wr_ptr_gray_sync, ae_level, underflow_clr,
        input  rd_addr, rd_ptr_gray, rd_empty, rd_almost_empty, rd_count, rd_underflow
    );

    modport slave (
        input  rd_en, wr_ptr_gray_sync, ae_level, underflow_clr,
        output rd_addr, rd_ptr_gray, rd_empty, rd_almost_empty, rd_count, rd_underflow
    );
endinterface

// File: rtl/fifo_rd_status.sv
// Read-domain pointer and status engine of the asynchronous FIFO: read address,
// Gray read pointer, empty / almost-empty flags, fill count and sticky underflow.
module fifo_rd_status #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   rd_clk,
    input  logic                   rst_n,
    fifo_rd_status_if.slave        bus
);
    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] rd_ptr_gray;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [PW-1:0] rd_count;
    logic          rd_underflow;

    logic          rd_fire;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] count_next;

    // Flags are computed from the next pointer so a draining read sets empty
    // on the same edge that consumes the last entry.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rd_fire    = bus.rd_en & ~rd_empty;
        bin_next   = rd_ptr_bin + PW'(rd_fire);
        gray_next  = (bin_next >> 1) ^ bin_next;
        wr_bin     = gray2bin(bus.wr_ptr_gray_sync);
        count_next = wr_bin - bin_next;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_bin      <= '0;
            rd_ptr_gray     <= '0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_count        <= '0;
            rd_underflow    <= 1'b0;
        end else begin
            rd_ptr_bin      <= bin_next;
            rd_ptr_gray     <= gray_next;
            rd_empty        <= (gray_next == bus.wr_ptr_gray_sync);
            rd_almost_empty <= (count_next <= bus.ae_level);
            rd_count        <= count_next;
            // Set has priority over clear.
            if (bus.rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end else if (bus.underflow_clr) begin
                rd_underflow <= 1'b0;
            end
        end
    end

    assign bus.rd_addr         = rd_ptr_bin[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray     = rd_ptr_gray;
    assign bus.rd_empty        = rd_empty;
    assign bus.rd_almost_empty = rd_almost_empty;
    assign bus.rd_count        = rd_count;
    assign bus.rd_underflow    = rd_underflow;

endmodule

// File: tb/tb_fifo_rd_status.sv
// Directed bench for fifo_rd_status (ADDR_WIDTH=4): a vector table for
// single-cycle behaviour plus sequences for drain, wrap and async reset.
module tb_fifo_rd_status;
    localparam int AW = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    fifo_rd_status_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_rd_status #(.ADDR_WIDTH(AW)) dut (
        .rd_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd_en;
        logic       clr;
        logic [4:0] wr_bin;
        logic [4:0] ae;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       empty;
        logic       ae_flag;
        logic [4:0] count;
        logic       uf;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic check_all(input string tag, input logic [3:0] addr, input logic [4:0] gray,
                             input logic empty, input logic ae_flag, input logic [4:0] count,
                             input logic uf);
        check({tag, " rd_addr"},         32'(bus.rd_addr),         32'(addr));
        check({tag, " rd_ptr_gray"},     32'(bus.rd_ptr_gray),     32'(gray));
        check({tag, " rd_empty"},        32'(bus.rd_empty),        32'(empty));
        check({tag, " rd_almost_empty"}, 32'(bus.rd_almost_empty), 32'(ae_flag));
        check({tag, " rd_count"},        32'(bus.rd_count),        32'(count));
        check({tag, " rd_underflow"},    32'(bus.rd_underflow),    32'(uf));
    endtask

    // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
    task automatic cycle(input logic rd_en, input logic clr, input logic [4:0] wr_bin,
                         input logic [4:0] ae);
        @(negedge clk);
        bus.rd_en            = rd_en;
        bus.underflow_clr    = clr;
        bus.wr_ptr_gray_sync = to_gray(wr_bin);
        bus.ae_level         = ae;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n                = 1'b0;
        bus.rd_en            = 1'b0;
        bus.underflow_clr    = 1'b0;
        bus.wr_ptr_gray_sync = '0;
        bus.ae_level         = 5'd1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.rd_en            = 1'b0;
        bus.underflow_clr    = 1'b0;
        bus.wr_ptr_gray_sync = '0;
        bus.ae_level         = 5'd1;

        // rd_en clr wr_bin ae | addr gray empty ae_flag count uf
        vecs[0]  = '{1'b0, 1'b0, 5'd0,  5'd1,  4'd0, 5'b00000, 1'b1, 1'b1, 5'd0,  1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'd3,  5'd1,  4'd0, 5'b00000, 1'b0, 1'b0, 5'd3,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd3,  5'd1,  4'd1, 5'b00001, 1'b0, 1'b0, 5'd2,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd3,  5'd1,  4'd2, 5'b00011, 1'b0, 1'b1, 5'd1,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5'd3,  5'd1,  4'd3, 5'b00010, 1'b1, 1'b1, 5'd0,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd3,  5'd1,  4'd3, 5'b00010, 1'b1, 1'b1, 5'd0,  1'b1};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  5'd1,  4'd3, 5'b00010, 1'b1, 1'b1, 5'd0,  1'b1};
        vecs[7]  = '{1'b0, 1'b1, 5'd3,  5'd1,  4'd3, 5'b00010, 1'b1, 1'b1, 5'd0,  1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd4,  5'd1,  4'd3, 5'b00010, 1'b0, 1'b1, 5'd1,  1'b0};
        vecs[9]  = '{1'b1, 1'b0, 5'd5,  5'd1,  4'd4, 5'b00110, 1'b0, 1'b1, 5'd1,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd5,  5'd0,  4'd4, 5'b00110, 1'b0, 1'b0, 5'd1,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 5'd5,  5'd0,  4'd5, 5'b00111, 1'b1, 1'b1, 5'd0,  1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'd21, 5'd16, 4'd5, 5'b00111, 1'b0, 1'b1, 5'd16, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 5'd21, 5'd15, 4'd5, 5'b00111, 1'b0, 1'b0, 5'd16, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        check_all("reset", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rd_en, vecs[i].clr, vecs[i].wr_bin, vecs[i].ae);
            check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].gray, vecs[i].empty,
                      vecs[i].ae_flag, vecs[i].count, vecs[i].uf);
        end

        // Full FIFO from reset, then drain all sixteen entries.
        do_reset();
        cycle(1'b0, 1'b0, 5'd16, 5'd1);
        check_all("full", 4'd0, 5'b00000, 1'b0, 1'b0, 5'd16, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 5'd16, 5'd1);
            check($sformatf("drain%0d rd_count", i), 32'(bus.rd_count), 32'(16 - i));
        end
        check_all("drained", 4'd0, 5'b11000, 1'b1, 1'b1, 5'd0, 1'b0);

        // Stream the read pointer to 30, then read across the wrap to 1.
        cycle(1'b0, 1'b0, 5'd30, 5'd1);
        check("pre-wrap rd_count", 32'(bus.rd_count), 32'd14);
        repeat (14) cycle(1'b1, 1'b0, 5'd30, 5'd1);
        check_all("at30", 4'd14, 5'b10001, 1'b1, 1'b1, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, 5'd1, 5'd1);
        check_all("wrap load", 4'd14, 5'b10001, 1'b0, 1'b0, 5'd3, 1'b0);
        cycle(1'b1, 1'b0, 5'd1, 5'd1);
        check_all("wrap r1", 4'd15, 5'b10000, 1'b0, 1'b0, 5'd2, 1'b0);
        cycle(1'b1, 1'b0, 5'd1, 5'd1);
        check_all("wrap r2", 4'd0, 5'b00000, 1'b0, 1'b1, 5'd1, 1'b0);
        cycle(1'b1, 1'b0, 5'd1, 5'd1);
        check_all("wrap r3", 4'd1, 5'b00001, 1'b1, 1'b1, 5'd0, 1'b0);

        // Asynchronous reset mid-stream with five entries pending.
        do_reset();
        cycle(1'b0, 1'b0, 5'd5, 5'd1);
        cycle(1'b1, 1'b0, 5'd5, 5'd1);
        check("pre-async rd_count", 32'(bus.rd_count), 32'd4);
        cycle(1'b0, 1'b0, 5'd6, 5'd1);
        check("count5 rd_count", 32'(bus.rd_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
        bus.wr_ptr_gray_sync = '0;
        bus.rd_en            = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post-reset no write", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
